// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the core LSU (m0)
// and the debug/DMA port (m1), with a bounded lock for m1 and alignment checking.
module data_ram_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [2:0]    m0_sel,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [2:0]    m1_sel,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [2:0]    ram_sel,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    typedef enum logic [1:0] {ARB, LOCKED, RELEASE} state_t;

    localparam logic [8:0] LMAX = LOCK_MAX[8:0];

    state_t     state, state_nxt;
    logic       last, last_nxt;   // 1 = master 1 won the most recent grant
    logic [7:0] cnt, cnt_nxt;
    logic [8:0] cnt_inc;
    logic       we_w, al_w, any_gnt;

    function automatic logic aligned(input logic [2:0] sel, input logic [1:0] a);
        case (sel)
            3'b000:  return 1'b1;
            3'b001:  return ~a[0];
            default: return a == 2'b00;
        endcase
    endfunction

    assign cnt_inc = {1'b0, cnt} + 9'd1;

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        // Grants are held low while reset is asserted, even with requests pending.
        if (rst) begin
            case (state)
                ARB: begin
                    if (m0_req && (!m1_req || last)) m0_gnt = 1'b1;
                    else if (m1_req)                 m1_gnt = 1'b1;
                    if (m1_gnt && m1_lock) begin
                        cnt_nxt   = 8'd1;
                        state_nxt = (LOCK_MAX <= 1) ? RELEASE : LOCKED;
                    end
                end
                LOCKED: begin
                    m1_gnt = m1_req;
                    if (!m1_lock) begin
                        state_nxt = ARB;
                        cnt_nxt   = 8'd0;
                    end else if (m1_gnt) begin
                        cnt_nxt = cnt_inc[7:0];
                        if (cnt_inc >= LMAX) state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    m0_gnt    = m0_req;
                    state_nxt = ARB;
                    cnt_nxt   = 8'd0;
                end
                default: state_nxt = ARB;
            endcase
            // Leaving RELEASE hands the next tie to master 1.
            if (state == RELEASE) last_nxt = 1'b0;
            else if (m0_gnt)      last_nxt = 1'b0;
            else if (m1_gnt)      last_nxt = 1'b1;
        end
    end

    assign any_gnt   = m0_gnt | m1_gnt;
    assign we_w      = m1_gnt ? m1_we : m0_we;
    assign ram_addr  = m1_gnt ? m1_addr : m0_addr;
    assign ram_sel   = m1_gnt ? m1_sel : m0_sel;
    assign ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign al_w      = aligned(ram_sel, ram_addr[1:0]);
    assign ram_ce    = any_gnt & ~we_w & al_w;
    assign ram_we    = any_gnt & we_w & al_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB;
            last      <= 1'b1;
            cnt       <= 8'd0;
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            cnt       <= cnt_nxt;
            m0_rvalid <= m0_gnt;
            m0_err    <= m0_gnt & ~al_w;
            m0_rdata  <= (m0_gnt && ram_ce) ? ram_rdata : '0;
            m1_rvalid <= m1_gnt;
            m1_err    <= m1_gnt & ~al_w;
            m1_rdata  <= (m1_gnt && ram_ce) ? ram_rdata : '0;
        end
    end
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Two-port arbiter sharing the single-port data RAM between master 0 (core load/store unit) and master 1 (debug/DMA port).
- Sits between the requesters and the RAM's ce/we/addr/sel/data interface.
- Grants one access per cycle with round-robin fairness, plus an optional bounded lock for master 1.
- Checks alignment, returns read data one cycle after grant, and flags misaligned accesses instead of issuing them.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- LOCK_MAX, 16, max consecutive cycles master 1 may hold the RAM under lock; 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- mN_req  in  1  master N (N=0,1) access request; held until granted
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  AW  byte address
- mN_sel  in  3  size: 000 byte, 001 half, other word
- mN_wdata  in  DW  write data, byte/half in low bits
- mN_gnt  out  1  request accepted this cycle (combinational)
- mN_rvalid  out  1  response valid, one cycle after gnt
- mN_rdata  out  DW  registered raw RAM word for reads; 0 for writes/errors
- mN_err  out  1  misaligned access; valid with rvalid
- m1_lock  in  1  keep grant on master 1 while asserted
- ram_ce  out  1  RAM read enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_sel  out  3  RAM size select
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM combinational read data

Behaviour:
- Reset (rst low, async): all gnt/rvalid/err = 0, all rdata = 0, ram_ce/ram_we = 0, last-winner pointer = master 1 (so master 0 wins first tie), lock counter = 0, FSM = ARB.
- FSM states:
  - ARB: normal round-robin.
  - LOCKED: master 1 owns the RAM.
  - RELEASE: one cycle in which master 1 is blocked.
- ARB grant rules:
  - Single requester wins.
  - If both request, the master not granted last wins; the pointer updates on every grant.
  - Master 1 granted with m1_lock=1 → go to LOCKED, counter = 1.
- LOCKED:
  - Only master 1 can be granted; master 0 gnt = 0.
  - Each m1 grant increments the counter.
  - m1_lock=0 → ARB next cycle.
  - Counter reaches LOCK_MAX → RELEASE.
- RELEASE:
  - Master 1 not granted; master 0 granted if requesting.
  - Then → ARB, with the pointer set to master 0.
- Grant cycle: ram_* driven combinationally from the winner.
  - ram_ce = 1 for reads; ram_we = 1 for writes.
  - Write takes effect at that clk edge.
  - Read: ram_rdata is sampled into the winner's rdata at the same edge.
- Response: winner's rvalid = 1 for exactly one cycle after gnt; err set per the alignment check. Back-to-back grants give back-to-back rvalid.
- Alignment check:
  - half with addr[0]=1 is misaligned; word with addr[1:0]≠00 is misaligned; byte is always aligned.
  - Misaligned request: still granted (consumes the slot), ram_ce = ram_we = 0, next cycle rvalid=1, err=1, rdata=0.
- No request or no grant: ram_ce = ram_we = 0; ram_addr/ram_sel/ram_wdata hold master 0 values (don't-care).
- Reset mid-access: any pending rvalid is cancelled; a write whose edge coincides with reset assertion is not guaranteed.
- Requesters must hold mN_* stable while req=1 and gnt=0; after gnt they may drop req or present a new request the next cycle.

Test Plan:
- Master 0 write word 0xDEADBEEF @0x10, then read @0x10 → gnt same cycle as req; next cycle rvalid=1, err=0, rdata=0xDEADBEEF.
- Both masters request reads continuously → grants alternate m0,m1,m0,m1 starting with m0 after reset; rvalid follows each grant by one cycle on the matching master.
- Master 1 half write 0xAAAA @0x22, then byte write 0x55 @0x20 → read word @0x20 = 0xAAAAxx55 (byte 1 unchanged); ram_sel 001 then 000 on the RAM.
- Misaligned: m0 word read @0x06, m1 half write @0x03 → each granted, ram_ce=ram_we=0, err=1 with rvalid, rdata=0, RAM contents unchanged.
- Lock with LOCK_MAX=4, m1_lock=1 and both masters requesting → m1 granted 4 consecutive cycles, m0 granted in RELEASE, then m1 re-granted under lock; m1_lock drop mid-sequence → ARB resumes next cycle.
- Assert rst low mid-stream with rvalid pending → outputs go to 0 immediately (asynchronously); after release, the first contended grant goes to m0.
